ec_point_addition: RTL and testbench

Computes the affine elliptic-curve point sum R = P + Q over the prime field GF(p) for distinct x-coordinates, as a multi-cycle sequential datapath. It sits below the scalar-multiplication controller, which routes doubling (P == Q) to a separate doubling block. One computation runs per reset release. Completion is reported through a sticky `result_ready` flag, or `infinity` when the sum is the point at infinity.

---
 rtl/ec_point_addition_pkg.sv | 43 ++++
 rtl/ec_point_addition_if.sv | 32 +++
 rtl/ec_point_addition_mod_inverse.sv | 91 +++++++++
 rtl/ec_point_addition.sv | 187 ++++++++++++++++++
 tb/tb_ec_point_addition.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/ec_point_addition_pkg.sv
// Shared definitions for the EC point-addition datapath.
//   FIELD_W : default field-element width in bits
//   state_t : controller states
//   mod_add / mod_sub / mod_half : modular helpers on a 32-bit working word
//            (operands expected < m, m odd and < 2^31)
package ecc_pkg;

    localparam int unsigned FIELD_W = 10;
    localparam int unsigned WORD_W  = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_INV,
        S_MUL_L,
        S_SQR,
        S_SUB_X,
        S_MUL_Y,
        S_SUB_Y,
        S_DONE,
        S_INF
    } state_t;

    // (a + b) mod m with a single conditional correction
    function automatic word_t mod_add(input word_t a, input word_t b, input word_t m);
        word_t s;
        s = a + b;
        return (s >= m) ? s - m : s;
    endfunction

    // (a - b) mod m: add m back when the subtraction borrows
    function automatic word_t mod_sub(input word_t a, input word_t b, input word_t m);
        return (a >= b) ? a - b : a - b + m;
    endfunction

    // a / 2 mod m for odd m
    function automatic word_t mod_half(input word_t a, input word_t m);
        return a[0] ? (a + m) >> 1 : a >> 1;
    endfunction

endpackage

// File: rtl/ec_point_addition_if.sv
// Operand/result bundle of the point adder.
//   p, x1, y1, x2, y2 : modulus and input points (master -> slave)
//   x3, y3            : sum coordinates (slave -> master)
//   result_ready      : sum valid, sticky until reset
//   infinity          : sum is the point at infinity, sticky until reset
interface ec_point_addition_if
    import ecc_pkg::*;
#(
    parameter int unsigned N = FIELD_W
) ();

    logic [N-1:0] p;
    logic [N-1:0] x1;
    logic [N-1:0] y1;
    logic [N-1:0] x2;
    logic [N-1:0] y2;
    logic [N-1:0] x3;
    logic [N-1:0] y3;
    logic         result_ready;
    logic         infinity;

    modport master (
        output p, x1, y1, x2, y2,
        input  x3, y3, result_ready, infinity
    );

    modport slave (
        input  p, x1, y1, x2, y2,
        output x3, y3, result_ready, infinity
    );

endinterface

// File: rtl/ec_point_addition_mod_inverse.sv
// Binary extended-Euclid modular inverse, one iteration per cycle.
//   clk, reset : clock, synchronous active-low reset
//   start      : one-cycle pulse loading a and p
//   a, p       : value to invert and odd modulus
//   inv        : a^-1 mod p (undefined if gcd(a,p) != 1)
//   done       : result valid; cleared by the next start
// Each iteration halves one of u or v, so 2N iterations always suffice;
// the counter cap keeps degenerate inputs from running forever.
module mod_inverse
    import ecc_pkg::*;
#(
    parameter int unsigned N = FIELD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] p,
    output logic [N-1:0] inv,
    output logic         done
);

    localparam int unsigned MAX_IT = 2 * N;
    localparam int unsigned CW     = $clog2(MAX_IT + 1);

    logic [N-1:0]  u, v, r, s, m;
    logic [CW-1:0] cnt;
    logic          busy;
    logic [N-1:0]  u_n, v_n, r_n, s_n;
    logic          finish_c;

    // Invariants: r*a == u and s*a == v (mod m)
    always_comb begin : step
        word_t mw;
        mw       = word_t'(m);
        u_n      = u;
        v_n      = v;
        r_n      = r;
        s_n      = s;
        finish_c = (u == N'(1)) || (v == N'(1)) || (cnt == CW'(MAX_IT));
        if (!u[0]) begin
            u_n = u >> 1;
            r_n = N'(mod_half(word_t'(r), mw));
        end else if (!v[0]) begin
            v_n = v >> 1;
            s_n = N'(mod_half(word_t'(s), mw));
        end else if (u >= v) begin
            u_n = (u - v) >> 1;
            r_n = N'(mod_half(mod_sub(word_t'(r), word_t'(s), mw), mw));
        end else begin
            v_n = (v - u) >> 1;
            s_n = N'(mod_half(mod_sub(word_t'(s), word_t'(r), mw), mw));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            u    <= '0;
            v    <= '0;
            r    <= '0;
            s    <= '0;
            m    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            inv  <= '0;
        end else if (start) begin
            u    <= a;
            v    <= p;
            r    <= N'(1);
            s    <= '0;
            m    <= p;
            cnt  <= '0;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            if (finish_c) begin
                busy <= 1'b0;
                done <= 1'b1;
                inv  <= (u == N'(1)) ? r : s;
            end else begin
                u   <= u_n;
                v   <= v_n;
                r   <= r_n;
                s   <= s_n;
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ec_point_addition.sv
// Affine elliptic-curve point addition R = P + Q over GF(p), x1 != x2.
//   clk   : clock
//   reset : synchronous active-low; release starts one computation
//   bus   : slave side of ec_point_addition_if (p, P, Q in; R and flags out)
// Sequence: capture -> check x1==x2 -> inverse -> lambda -> lambda^2 ->
// x3 -> lambda*(x1-x3) -> y3. One MSB-first shift-add multiplier is shared
// by the three multiply states.
module ec_point_addition
    import ecc_pkg::*;
#(
    parameter int unsigned n = FIELD_W
) (
    input  logic               clk,
    input  logic               reset,
    ec_point_addition_if.slave bus
);

    localparam int unsigned   W       = n + 1;
    localparam int unsigned   CW      = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0] BIT_TOP = CW'(n - 1);

    state_t state, state_d;

    logic [W-1:0]  p_r, x1_r, y1_r, x2_r, y2_r, dy_r, inv_r, lam_r, t_r, acc_r;
    logic [n-1:0]  x3i_r;
    logic [CW-1:0] bit_cnt;
    logic [n-1:0]  x3_q, y3_q;
    logic          result_ready_q, infinity_q;

    logic          inv_start_c, inv_done;
    logic [n-1:0]  inv_q;
    logic          same_x_c, bit_last_c;
    logic [W-1:0]  mul_a_c, mul_b_c, acc_next_c, dy_c, x3_new_c, t_new_c;
    logic [n-1:0]  d_c, y3_new_c;

    assign bus.x3           = x3_q;
    assign bus.y3           = y3_q;
    assign bus.result_ready = result_ready_q;
    assign bus.infinity     = infinity_q;

    assign same_x_c   = (x1_r == x2_r);
    assign bit_last_c = (bit_cnt == '0);

    mod_inverse #(.N(n)) u_inv (
        .clk   (clk),
        .reset (reset),
        .start (inv_start_c),
        .a     (d_c),
        .p     (p_r[n-1:0]),
        .inv   (inv_q),
        .done  (inv_done)
    );

    // Shared multiplier step plus the modular subtractions
    always_comb begin : datapath
        word_t pw, dbl;
        pw      = word_t'(p_r);
        mul_a_c = '0;
        mul_b_c = '0;
        case (state)
            S_MUL_L: begin mul_a_c = dy_r;  mul_b_c = inv_r; end
            S_SQR:   begin mul_a_c = lam_r; mul_b_c = lam_r; end
            S_MUL_Y: begin mul_a_c = lam_r; mul_b_c = t_r;   end
            default: ;
        endcase
        dbl = mod_add(word_t'(acc_r), word_t'(acc_r), pw);
        if (mul_b_c[bit_cnt]) begin
            acc_next_c = W'(mod_add(dbl, word_t'(mul_a_c), pw));
        end else begin
            acc_next_c = W'(dbl);
        end
        d_c      = n'(mod_sub(word_t'(x2_r), word_t'(x1_r), pw));
        dy_c     = W'(mod_sub(word_t'(y2_r), word_t'(y1_r), pw));
        x3_new_c = W'(mod_sub(mod_sub(word_t'(acc_r), word_t'(x1_r), pw), word_t'(x2_r), pw));
        t_new_c  = W'(mod_sub(word_t'(x1_r), word_t'(x3_new_c), pw));
        y3_new_c = n'(mod_sub(word_t'(acc_r), word_t'(y1_r), pw));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic and inverse start strobe
    always_comb begin
        state_d     = state;
        inv_start_c = 1'b0;
        case (state)
            S_IDLE:  state_d = S_CHECK;
            S_CHECK: begin
                if (same_x_c) begin
                    state_d = S_INF;
                end else begin
                    inv_start_c = 1'b1;
                    state_d     = S_INV;
                end
            end
            S_INV:   if (inv_done) state_d = S_MUL_L;
            S_MUL_L: if (bit_last_c) state_d = S_SQR;
            S_SQR:   if (bit_last_c) state_d = S_SUB_X;
            S_SUB_X: state_d = S_MUL_Y;
            S_MUL_Y: if (bit_last_c) state_d = S_SUB_Y;
            S_SUB_Y: state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            S_INF:   state_d = S_INF;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            p_r            <= '0;
            x1_r           <= '0;
            y1_r           <= '0;
            x2_r           <= '0;
            y2_r           <= '0;
            dy_r           <= '0;
            inv_r          <= '0;
            lam_r          <= '0;
            t_r            <= '0;
            acc_r          <= '0;
            x3i_r          <= '0;
            bit_cnt        <= '0;
            x3_q           <= '0;
            y3_q           <= '0;
            result_ready_q <= 1'b0;
            infinity_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    p_r  <= W'(bus.p);
                    x1_r <= W'(bus.x1);
                    y1_r <= W'(bus.y1);
                    x2_r <= W'(bus.x2);
                    y2_r <= W'(bus.y2);
                end
                S_CHECK: begin
                    dy_r <= dy_c;
                    if (same_x_c) infinity_q <= 1'b1;
                end
                S_INV: begin
                    if (inv_done) begin
                        inv_r   <= W'(inv_q);
                        acc_r   <= '0;
                        bit_cnt <= BIT_TOP;
                    end
                end
                S_MUL_L: begin
                    acc_r   <= acc_next_c;
                    bit_cnt <= bit_cnt - CW'(1);
                    if (bit_last_c) begin
                        lam_r   <= acc_next_c;
                        acc_r   <= '0;
                        bit_cnt <= BIT_TOP;
                    end
                end
                S_SQR: begin
                    // lambda^2 is left in acc_r for the x3 step
                    acc_r   <= acc_next_c;
                    bit_cnt <= bit_cnt - CW'(1);
                    if (bit_last_c) bit_cnt <= BIT_TOP;
                end
                S_SUB_X: begin
                    x3i_r   <= n'(x3_new_c);
                    t_r     <= t_new_c;
                    acc_r   <= '0;
                    bit_cnt <= BIT_TOP;
                end
                S_MUL_Y: begin
                    acc_r   <= acc_next_c;
                    bit_cnt <= bit_cnt - CW'(1);
                end
                S_SUB_Y: begin
                    x3_q           <= x3i_r;
                    y3_q           <= y3_new_c;
                    result_ready_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ec_point_addition.sv
// Self-checking bench for ec_point_addition: directed vectors, reset and
// input-change behaviour, and random additions on p=1021 against an
// integer reference model.
module tb_ec_point_addition;

    localparam int unsigned N       = 10;
    localparam int          LAT_MAX = 5 * N + 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    ec_point_addition_if #(.N(N)) bus ();

    ec_point_addition #(.n(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int md(input int a, input int p);
        int r;
        r = a % p;
        if (r < 0) r += p;
        return r;
    endfunction

    // Inverse by exhaustive search: slow but obviously correct
    function automatic int inv_ref(input int a, input int p);
        for (int i = 1; i < p; i++) begin
            if ((a * i) % p == 1) return i;
        end
        return 0;
    endfunction

    task automatic ref_add(input int p, input int x1, input int y1, input int x2, input int y2,
                           output int x3, output int y3, output bit inf);
        int lam;
        if (x1 == x2) begin
            inf = 1'b1;
            x3  = 0;
            y3  = 0;
        end else begin
            inf = 1'b0;
            lam = md(md(y2 - y1, p) * inv_ref(md(x2 - x1, p), p), p);
            x3  = md(lam * lam - x1 - x2, p);
            y3  = md(lam * (x1 - x3) - y1, p);
        end
    endtask

    task automatic apply(input int p, input int x1, input int y1, input int x2, input int y2);
        bus.p  = N'(p);
        bus.x1 = N'(x1);
        bus.y1 = N'(y1);
        bus.x2 = N'(x2);
        bus.y2 = N'(y2);
    endtask

    // Reset for two cycles with operands applied, then release at a negedge
    task automatic start_op(input int p, input int x1, input int y1, input int x2, input int y2);
        @(negedge clk);
        reset = 1'b0;
        apply(p, x1, y1, x2, y2);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Cycles until a flag is seen, sampled at negedges; bounded
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < LAT_MAX + 20) begin
            @(negedge clk);
            cyc++;
            if (bus.result_ready || bus.infinity) break;
        end
    endtask

    task automatic check_result(input string tag, input int ex, input int ey, input bit ei,
                                input int cyc, input int hold);
        if (ei) begin
            check({tag, "/inf_latency"}, cyc, 2);
        end else begin
            check({tag, "/latency_ok"}, int'(cyc <= LAT_MAX), 1);
        end
        check({tag, "/result_ready"}, int'(bus.result_ready), int'(!ei));
        check({tag, "/infinity"}, int'(bus.infinity), int'(ei));
        check({tag, "/x3"}, int'(bus.x3), ex);
        check({tag, "/y3"}, int'(bus.y3), ey);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "/sticky_ready"}, int'(bus.result_ready), int'(!ei));
            check({tag, "/sticky_inf"}, int'(bus.infinity), int'(ei));
            check({tag, "/hold_xy"}, int'({bus.x3, bus.y3}), (ex << N) | ey);
        end
    endtask

    task automatic run_case(input string tag, input int p, input int x1, input int y1,
                            input int x2, input int y2, input int hold);
        int ex, ey, cyc;
        bit ei;
        ref_add(p, x1, y1, x2, y2, ex, ey, ei);
        start_op(p, x1, y1, x2, y2);
        wait_done(cyc);
        check_result(tag, ex, ey, ei, cyc, hold);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "/x3_zero"}, int'(bus.x3), 0);
        check({tag, "/y3_zero"}, int'(bus.y3), 0);
        check({tag, "/ready_zero"}, int'(bus.result_ready), 0);
        check({tag, "/inf_zero"}, int'(bus.infinity), 0);
    endtask

    initial begin
        int ex, ey, cyc, x1, y1, x2, y2;
        bit ei;

        apply(17, 6, 3, 5, 1);
        repeat (3) @(negedge clk);
        check_cleared("reset_state");

        run_case("p17_a", 17, 6, 3, 5, 1, 5);
        run_case("p17_comm", 17, 5, 1, 6, 3, 0);
        run_case("p23", 23, 3, 10, 9, 7, 0);
        run_case("p17_inf", 17, 5, 1, 5, 16, 5);

        // Reset after completion clears outputs at the next edge
        run_case("p17_pre_rst", 17, 6, 3, 5, 1, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_cleared("rst_after_done");

        // Operands changing mid-run must not affect the result
        ref_add(17, 6, 3, 5, 1, ex, ey, ei);
        start_op(17, 6, 3, 5, 1);
        repeat (4) @(negedge clk);
        apply(17, 2, 7, 11, 9);
        wait_done(cyc);
        check_result("mid_change", ex, ey, ei, cyc + 4, 0);

        // Reset while the inverse is running
        start_op(17, 6, 3, 5, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_cleared("rst_in_inv");
        run_case("p17_restart", 17, 6, 3, 5, 1, 0);

        // Random additions on p=1021
        for (int k = 0; k < 20; k++) begin
            x1 = int'($urandom_range(0, 1020));
            y1 = int'($urandom_range(0, 1020));
            y2 = int'($urandom_range(0, 1020));
            do begin
                x2 = int'($urandom_range(0, 1020));
            end while (x2 == x1);
            run_case($sformatf("rand%0d", k), 1021, x1, y1, x2, y2, (k == 0) ? 20 : 0);
        end

        x1 = int'($urandom_range(1, 1020));
        y1 = int'($urandom_range(1, 1020));
        run_case("rand_inf", 1021, x1, y1, x1, 1021 - y1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
